regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (RegWrt / write address / write data) between NUM_REQ writeback sources, e.g. ALU, load unit and link-address writer.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered write-port outputs.
- Keeps a 32-entry pending-write scoreboard so decode can detect read-after-write hazards against registers still awaiting writeback.

---
 rtl/regfile_wb_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback
// sources, with a pending-write scoreboard for RAW hazard detection. Option: ZERO_REG_PROTECT_EN.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_addr,
    input  logic [ADDR_W-1:0]         query_addr1,
    input  logic [ADDR_W-1:0]         query_addr2,
    output logic                      busy1,
    output logic                      busy2,
    output logic                      RegWrt,
    output logic [ADDR_W-1:0]         WriteReg,
    output logic [DATA_W-1:0]         WriteData,
    output logic [2:0]                grant_id
);
    localparam int unsigned SB_DEPTH = 2 ** ADDR_W;

    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic [2:0]          gnt_idx;
    logic                gnt_found;
    logic                xfer;
    logic [NUM_REQ-1:0]  ready_d;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                wr_en;
    logic                set_en;

    logic                regwrt_q;
    logic [ADDR_W-1:0]   writereg_q;
    logic [DATA_W-1:0]   writedata_q;
    logic [2:0]          grant_q;
    logic [SB_DEPTH-1:0] sb_q, sb_d;

    // Scan offsets from rr_ptr; the first valid requester in rotated order wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!gnt_found && req_valid[j] && (((32'(rr_ptr_q) + i) % NUM_REQ) == j)) begin
                    gnt_found = 1'b1;
                    gnt_idx   = 3'(j);
                end
            end
        end
    end

    always_comb begin
        ready_d  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (gnt_idx == 3'(j)) begin
                ready_d[j] = gnt_found & rst_n;
                sel_addr   = req_addr[j*ADDR_W +: ADDR_W];
                sel_data   = req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer     = gnt_found & rst_n;
    assign rr_ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? 3'd0 : gnt_idx + 3'd1;

`ifdef ZERO_REG_PROTECT_EN
    assign wr_en  = (sel_addr != '0);
    assign set_en = issue_valid && (issue_addr != '0);
    assign busy1  = sb_q[query_addr1] && (query_addr1 != '0);
    assign busy2  = sb_q[query_addr2] && (query_addr2 != '0);
`else
    assign wr_en  = 1'b1;
    assign set_en = issue_valid;
    assign busy1  = sb_q[query_addr1];
    assign busy2  = sb_q[query_addr2];
`endif

    // Set is applied after clear so a re-issued destination stays outstanding.
    always_comb begin
        sb_d = sb_q;
        if (regwrt_q) sb_d[writereg_q] = 1'b0;
        if (set_en)   sb_d[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            regwrt_q    <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
            grant_q     <= '0;
            sb_q        <= '0;
        end else begin
            sb_q <= sb_d;
            if (xfer) begin
                rr_ptr_q    <= rr_ptr_d;
                regwrt_q    <= wr_en;
                writereg_q  <= sel_addr;
                writedata_q <= sel_data;
                grant_q     <= gnt_idx;
            end else begin
                regwrt_q    <= 1'b0;
            end
        end
    end

    assign req_ready = ready_d;
    assign RegWrt    = regwrt_q;
    assign WriteReg  = writereg_q;
    assign WriteData = writedata_q;
    assign grant_id  = grant_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued at handshake time
// and compared against the registered write port one cycle later.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        issue_valid;
    logic [4:0]  issue_addr, query_addr1, query_addr2;
    logic        busy1, busy2, RegWrt;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [2:0]  grant_id;

    typedef struct {
        logic        wrt;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [2:0]  id;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .issue_valid(issue_valid),
        .issue_addr(issue_addr), .query_addr1(query_addr1), .query_addr2(query_addr2),
        .busy1(busy1), .busy2(busy2), .RegWrt(RegWrt), .WriteReg(WriteReg),
        .WriteData(WriteData), .grant_id(grant_id)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Check ready at negedge and queue the expected write for the granted index.
    task automatic accept(input logic [2:0] exp_rdy, input string tag);
        exp_t e;
        int   id;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
        id = (exp_rdy == 3'b001) ? 0 : (exp_rdy == 3'b010) ? 1 : (exp_rdy == 3'b100) ? 2 : -1;
        if (id >= 0) begin
            e.addr = req_addr[id*5 +: 5];
            e.data = req_data[id*32 +: 32];
            e.id   = 3'(id);
`ifdef ZERO_REG_PROTECT_EN
            e.wrt  = (e.addr != 5'd0);
`else
            e.wrt  = 1'b1;
`endif
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_port(input string tag);
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_RegWrt"}, 64'(RegWrt), 64'(e.wrt));
            if (e.wrt) begin
                chk({tag, "_WriteReg"},  64'(WriteReg),  64'(e.addr));
                chk({tag, "_WriteData"}, 64'(WriteData), 64'(e.data));
                chk({tag, "_grant_id"},  64'(grant_id),  64'(e.id));
            end
        end else begin
            chk({tag, "_RegWrt_idle"}, 64'(RegWrt), 64'd0);
        end
    endtask

    task automatic step(input logic [2:0] exp_rdy, input string tag);
        accept(exp_rdy, tag);
        check_port(tag);
    endtask

    task automatic scan_sb_clear(input string tag);
        for (int a = 0; a < 32; a++) begin
            query_addr1 = 5'(a);
            #1;
            chk({tag, "_sb_clear"}, 64'(busy1), 64'd0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 3'b111;
        req_addr    = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        query_addr1 = '0;
        query_addr2 = '0;
        #3;
        chk("rst_ready",     64'(req_ready), 64'd0);
        chk("rst_RegWrt",    64'(RegWrt),    64'd0);
        chk("rst_WriteReg",  64'(WriteReg),  64'd0);
        chk("rst_WriteData", 64'(WriteData), 64'd0);
        chk("rst_grant_id",  64'(grant_id),  64'd0);
        req_valid = '0;
        scan_sb_clear("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fairness: all valid, rotation from pointer 0
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        step(3'b001, "rr0");
        step(3'b010, "rr1");
        step(3'b100, "rr2");
        step(3'b001, "rr3");
        step(3'b010, "rr4");
        step(3'b100, "rr5");
        req_valid = '0;
        step(3'b000, "rr_end");

        // Single requester 1
        req_valid = 3'b010;
        req_addr  = {5'd0, 5'd7, 5'd0};
        req_data  = {32'h0, 32'hDEADBEEF, 32'h0};
        step(3'b010, "single");
        req_valid = '0;
        step(3'b000, "single_idle");

        // Register 0 write from requester 1; pointer then favours requester 2
        req_valid = 3'b010;
        req_addr  = {5'd0, 5'd0, 5'd0};
        req_data  = {32'h0, 32'h1, 32'h0};
        step(3'b010, "zero");
        req_valid = 3'b101;
        req_addr  = {5'd12, 5'd0, 5'd11};
        req_data  = {32'h22, 32'h0, 32'h11};
        step(3'b100, "after_zero");
        req_valid = '0;
        step(3'b000, "after_zero_idle");

        // Scoreboard set and clear
        issue_valid = 1'b1;
        issue_addr  = 5'd9;
        step(3'b000, "issue9");
        issue_valid = 1'b0;
        query_addr1 = 5'd9;
        query_addr2 = 5'd8;
        #1;
        chk("busy1_set",  64'(busy1), 64'd1);
        chk("busy2_other", 64'(busy2), 64'd0);
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd9};
        req_data  = {32'h0, 32'h0, 32'h99};
        step(3'b001, "wr9");
        chk("busy1_during_write", 64'(busy1), 64'd1);
        req_valid = '0;
        step(3'b000, "clear9");
        chk("busy1_cleared", 64'(busy1), 64'd0);

        // Set wins over clear on the same edge
        issue_valid = 1'b1;
        step(3'b000, "reissue9");
        issue_valid = 1'b0;
        req_valid   = 3'b001;
        req_data    = {32'h0, 32'h0, 32'h98};
        step(3'b001, "wr9b");
        req_valid   = '0;
        issue_valid = 1'b1;
        step(3'b000, "set_and_clear9");
        issue_valid = 1'b0;
        query_addr2 = 5'd9;
        #1;
        chk("busy1_set_wins", 64'(busy1), 64'd1);
        chk("busy2_set_wins", 64'(busy2), 64'd1);

        // Register 0 tracking
        issue_valid = 1'b1;
        issue_addr  = 5'd0;
        step(3'b000, "issue0");
        issue_valid = 1'b0;
        query_addr1 = 5'd0;
        #1;
`ifdef ZERO_REG_PROTECT_EN
        chk("busy1_reg0", 64'(busy1), 64'd0);
`else
        chk("busy1_reg0", 64'(busy1), 64'd1);
`endif

        // Reset between acceptance and the write cycle; pointer starts at 1 before reset
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd3};
        req_data  = {32'h0, 32'h0, 32'h33};
        accept(3'b001, "pre_rst");
        req_valid = '0;
        check_port("pre_rst");
        rst_n = 1'b0;
        #1;
        chk("midrst_RegWrt",   64'(RegWrt),    64'd0);
        chk("midrst_WriteReg", 64'(WriteReg),  64'd0);
        chk("midrst_grant_id", 64'(grant_id),  64'd0);
        scan_sb_clear("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = 3'b101;
        req_addr  = {5'd20, 5'd0, 5'd21};
        req_data  = {32'h2020, 32'h0, 32'h2121};
        step(3'b001, "post_rst_first");
        req_valid = 3'b100;
        step(3'b100, "post_rst_second");
        req_valid = '0;
        step(3'b000, "post_rst_idle");
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
